ffmul_result_drain: RTL and testbench
=====================================

Name: ffmul_result_drain

Overview:
- Output stage directly downstream of the finite-field multiplier.
- Accepts one full-width product (up to 409 bits) plus its field-select code in a single handshake.
- Returns the product to the core as a sequence of 32-bit words, least-significant word first, over a valid/ready interface.
- Word count and final-word masking follow the selected field: GF(2^409), GF(2^233), GF(2^193) or GF(2^113).

Parameters:
- WIDTH, 409, width of the multiplier result bus.
- XLEN, 32, width of the output word.

Ports:
- clk  input  1  core clock.
- rst_l  input  1  asynchronous active-low reset.
- res_valid_i  input  1  multiplier presents a product.
- res_ready_o  output  1  drain can accept a product.
- res_op_i  input  2  field select: 00=409, 01=233, 10=193, 11=113.
- res_data_i  input  WIDTH  product; bit 0 is the x^0 coefficient.
- flush_i  input  1  synchronous abort of any drain in progress.
- out_valid_o  output  1  out_data_o holds a valid word.
- out_ready_i  input  1  consumer accepts the word.
- out_data_o  output  XLEN  current result word.
- out_idx_o  output  4  index of the current word, 0-based.
- out_last_o  output  1  current word is the final word of the product.
- busy_o  output  1  drain state is not IDLE.

Behaviour:
- Reset (rst_l low, asynchronous):
  - state = IDLE.
  - out_valid_o = 0, out_data_o = 0, out_idx_o = 0, out_last_o = 0, busy_o = 0.
  - Internal buffer cleared.
  - res_ready_o = 1 once reset is released.
- States:
  - IDLE: res_ready_o = 1, out_valid_o = 0.
  - DRAIN: out_valid_o = 1.
- Capture:
  - Occurs when res_valid_i & res_ready_o are both high.
  - Latch res_data_i with bits at index >= m forced to 0, where m = 409/233/193/113 per res_op_i.
  - Latch the word count N = 13/8/7/4 and the field code.
  - Next state is DRAIN with index = 0.
- Latency: a product captured at edge t gives out_valid_o = 1 with word 0 in the cycle after t.
- Word mapping:
  - Word k = buffer bits [32k+31 : 32k].
  - Bits beyond WIDTH read as 0.
  - The valid bits of the final word are [24:0] for 409, [8:0] for 233, [0] for 193 and [16:0] for 113; all higher bits are 0.
- Beat transfer:
  - A beat transfers when out_valid_o & out_ready_i are both high.
  - On transfer the index increments.
  - out_last_o = (index == N-1) while in DRAIN.
  - On transfer of the last word, return to IDLE.
- Stall: while out_valid_o & !out_ready_i, out_data_o, out_idx_o and out_last_o hold stable.
- Back-to-back products:
  - res_ready_o = IDLE | (DRAIN & out_last_o & out_ready_i).
  - A new product captured in the same cycle the last word transfers goes straight to DRAIN, index 0, with no bubble.
- Flush:
  - flush_i high forces state to IDLE and out_valid_o to 0 at the next edge, and discards the buffer.
  - flush_i has priority over both capture and beat transfer in the same cycle.
  - res_ready_o is forced to 0 during a flush cycle.
- Valid rule: out_valid_o, once asserted, never drops without a transfer, except on flush or reset.
- res_op_i and res_data_i are sampled only at capture; later changes are ignored.
- busy_o = (state != IDLE).

Test Plan:
- FF409 product with all bits 1, out_ready_i held at 1 -> 13 consecutive beats, idx 0..12; words 0..11 = 0xFFFFFFFF; word 12 = 0x01FFFFFF; out_last_o only on idx 12; then IDLE.
- FF113 product with all bits 1, out_ready_i toggling 1,0,1,0 -> 4 beats; words 0..2 = 0xFFFFFFFF; word 3 = 0x0001FFFF; data and idx stable during stalls; total 7 cycles from first valid to IDLE.
- FF193 product with bit 192 = 1, then FF233 product offered during the last beat with out_ready_i = 1 -> 7 words with word 6 = 0x00000001; second product captured that cycle; next cycle word 0 of the 233 product, 8 beats, word 7 masked to [8:0].
- FF233 drain, flush_i pulsed after idx 3 transfers, res_valid_i also high that cycle -> next cycle state IDLE, out_valid_o = 0, no capture; the following cycle res_ready_o = 1 and a new product is accepted.
- rst_l asserted low mid-drain at idx 5 of FF409 -> outputs go to zero immediately; after release, IDLE with res_ready_o = 1 and no leftover words emitted.

Source files
------------

// File: rtl/ffmul_result_drain_if.sv
// rtl/ffmul_result_drain_if.sv - product capture and word-drain handshake bundle
interface ffmul_result_drain_if #(
  parameter int WIDTH = 409,
  parameter int XLEN  = 32
);
  logic             res_valid_i;
  logic             res_ready_o;
  logic [1:0]       res_op_i;
  logic [WIDTH-1:0] res_data_i;
  logic             flush_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [XLEN-1:0]  out_data_o;
  logic [3:0]       out_idx_o;
  logic             out_last_o;
  logic             busy_o;

  modport slave (
    input  res_valid_i, res_op_i, res_data_i, flush_i, out_ready_i,
    output res_ready_o, out_valid_o, out_data_o, out_idx_o, out_last_o, busy_o
  );

  modport master (
    output res_valid_i, res_op_i, res_data_i, flush_i, out_ready_i,
    input  res_ready_o, out_valid_o, out_data_o, out_idx_o, out_last_o, busy_o
  );
endinterface

// File: rtl/ffmul_result_drain.sv
// rtl/ffmul_result_drain.sv - drains a finite-field product as LSW-first 32-bit words
module ffmul_result_drain #(
  parameter int WIDTH = 409,
  parameter int XLEN  = 32
) (
  input  logic                clk,
  input  logic                rst_l,
  ffmul_result_drain_if.slave bus
);
  localparam int NWORDS = (WIDTH + XLEN - 1) / XLEN;
  localparam int PADW   = NWORDS * XLEN;

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] buf_q, buf_d;
  logic [1:0]       op_q, op_d;
  logic [3:0]       idx_q, idx_d;

  logic [PADW-1:0]  padded;
  logic [WIDTH-1:0] cap_mask;
  logic             last_word;
  logic             beat;
  logic             res_ready;
  logic             capture;

  function automatic int field_bits(input logic [1:0] op);
    case (op)
      2'b00:   return 409;
      2'b01:   return 233;
      2'b10:   return 193;
      default: return 113;
    endcase
  endfunction

  function automatic logic [3:0] word_count(input logic [1:0] op);
    case (op)
      2'b00:   return 4'd13;
      2'b01:   return 4'd8;
      2'b10:   return 4'd7;
      default: return 4'd4;
    endcase
  endfunction

  // Masking at capture keeps the buffer clean, so the final word needs no extra gating.
  assign cap_mask  = {WIDTH{1'b1}} >> (WIDTH - field_bits(bus.res_op_i));
  assign padded    = {{(PADW - WIDTH){1'b0}}, buf_q};
  assign last_word = (state_q == DRAIN) && (idx_q == word_count(op_q) - 4'd1);
  assign beat      = (state_q == DRAIN) && bus.out_ready_i;
  assign res_ready = !bus.flush_i &&
                     ((state_q == IDLE) || (last_word && bus.out_ready_i));
  assign capture   = bus.res_valid_i && res_ready;

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    op_d    = op_q;
    idx_d   = idx_q;
    if (bus.flush_i) begin
      state_d = IDLE;
      buf_d   = '0;
      idx_d   = 4'd0;
    end else if (capture) begin
      state_d = DRAIN;
      buf_d   = bus.res_data_i & cap_mask;
      op_d    = bus.res_op_i;
      idx_d   = 4'd0;
    end else if (beat) begin
      if (last_word) begin
        state_d = IDLE;
        idx_d   = 4'd0;
      end else begin
        idx_d   = idx_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q <= IDLE;
      buf_q   <= '0;
      op_q    <= 2'b00;
      idx_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
    end
  end

  assign bus.res_ready_o = res_ready;
  assign bus.out_valid_o = (state_q == DRAIN);
  assign bus.out_data_o  = (state_q == DRAIN) ? padded[int'(idx_q) * XLEN +: XLEN] : '0;
  assign bus.out_idx_o   = idx_q;
  assign bus.out_last_o  = last_word;
  assign bus.busy_o      = (state_q != IDLE);
endmodule

// File: tb/tb_ffmul_result_drain.sv
// tb/tb_ffmul_result_drain.sv - directed and randomized checks of the result drain
module tb_ffmul_result_drain;
  logic clk = 1'b0;
  logic rst_l = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  ffmul_result_drain_if #(.WIDTH(409), .XLEN(32)) dif ();

  ffmul_result_drain #(.WIDTH(409), .XLEN(32)) dut (
    .clk  (clk),
    .rst_l(rst_l),
    .bus  (dif.slave)
  );

  function automatic int nwords(input logic [1:0] op);
    case (op)
      2'b00:   return 13;
      2'b01:   return 8;
      2'b10:   return 7;
      default: return 4;
    endcase
  endfunction

  function automatic int mbits(input logic [1:0] op);
    case (op)
      2'b00:   return 409;
      2'b01:   return 233;
      2'b10:   return 193;
      default: return 113;
    endcase
  endfunction

  // Reference: word k is coefficients 32k..32k+31, zero at or above the field degree.
  function automatic logic [31:0] exp_word(input logic [1:0] op, input logic [408:0] d, input int k);
    logic [31:0] w;
    for (int b = 0; b < 32; b++) begin
      int pos;
      pos  = 32 * k + b;
      w[b] = (pos < mbits(op)) ? d[pos] : 1'b0;
    end
    return w;
  endfunction

  function automatic logic [408:0] rand_vec();
    logic [415:0] t;
    for (int i = 0; i < 13; i++) t[i*32 +: 32] = $urandom;
    return t[408:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    check({tag, "_valid"}, 32'(dif.out_valid_o), 32'd0);
    check({tag, "_busy"}, 32'(dif.busy_o), 32'd0);
    check({tag, "_res_ready"}, 32'(dif.res_ready_o), 32'd1);
    check({tag, "_idx"}, 32'(dif.out_idx_o), 32'd0);
    check({tag, "_last"}, 32'(dif.out_last_o), 32'd0);
    check({tag, "_data"}, dif.out_data_o, 32'd0);
  endtask

  task automatic offer(input logic [1:0] op, input logic [408:0] d);
    @(negedge clk);
    dif.res_valid_i = 1'b1;
    dif.res_op_i    = op;
    dif.res_data_i  = d;
    #1 check("offer_ready", 32'(dif.res_ready_o), 32'd1);
    @(posedge clk);
    #1;
    dif.res_valid_i = 1'b0;
    dif.res_data_i  = rand_vec();
    dif.res_op_i    = 2'($urandom);
  endtask

  // mode 0: always ready, 1: ready toggling from 1, 2: random ready
  task automatic drain(input logic [1:0] op, input logic [408:0] d, input int mode, input int stop_at,
                       input bit chain, input logic [1:0] cop, input logic [408:0] cd, output int cycles);
    int k;
    int n;
    bit rdy;
    k = 0;
    n = nwords(op);
    cycles = 0;
    while (k < stop_at && cycles < 200) begin
      @(negedge clk);
      check("beat_valid", 32'(dif.out_valid_o), 32'd1);
      check("beat_busy", 32'(dif.busy_o), 32'd1);
      check($sformatf("beat_idx_k%0d", k), 32'(dif.out_idx_o), 32'(k));
      check($sformatf("beat_data_op%0d_k%0d", op, k), dif.out_data_o, exp_word(op, d, k));
      check($sformatf("beat_last_k%0d", k), 32'(dif.out_last_o), 32'(k == n - 1));
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cycles % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      dif.out_ready_i = rdy;
      if (chain && k == n - 1 && rdy) begin
        dif.res_valid_i = 1'b1;
        dif.res_op_i    = cop;
        dif.res_data_i  = cd;
      end
      #1 check($sformatf("drain_res_ready_k%0d", k), 32'(dif.res_ready_o), 32'(k == n - 1 && rdy));
      @(posedge clk);
      #1;
      dif.res_valid_i = 1'b0;
      dif.res_data_i  = rand_vec();
      dif.res_op_i    = 2'($urandom);
      cycles++;
      if (rdy) k++;
    end
    if (k < stop_at) check("drain_timeout", 32'(k), 32'(stop_at));
    dif.out_ready_i = 1'b0;
  endtask

  initial begin
    logic [408:0] ones;
    logic [408:0] d193;
    logic [408:0] rd;
    logic [408:0] nd;
    logic [1:0]   rop;
    int           cyc;

    ones = '1;
    d193 = ~((409'(1) << 192) - 409'(1));
    dif.res_valid_i = 1'b0;
    dif.res_op_i    = 2'b00;
    dif.res_data_i  = '0;
    dif.flush_i     = 1'b0;
    dif.out_ready_i = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_valid", 32'(dif.out_valid_o), 32'd0);
    check("rst_data", dif.out_data_o, 32'd0);
    check("rst_idx", 32'(dif.out_idx_o), 32'd0);
    check("rst_last", 32'(dif.out_last_o), 32'd0);
    check("rst_busy", 32'(dif.busy_o), 32'd0);
    rst_l = 1'b1;
    idle_check("post_rst");

    offer(2'b00, ones);
    drain(2'b00, ones, 0, 13, 1'b0, 2'b00, '0, cyc);
    check("ff409_cycles", 32'(cyc), 32'd13);
    idle_check("ff409_end");

    offer(2'b11, ones);
    drain(2'b11, ones, 1, 4, 1'b0, 2'b00, '0, cyc);
    check("ff113_cycles", 32'(cyc), 32'd7);
    idle_check("ff113_end");

    offer(2'b10, d193);
    drain(2'b10, d193, 0, 7, 1'b1, 2'b01, ones, cyc);
    drain(2'b01, ones, 0, 8, 1'b0, 2'b00, '0, cyc);
    check("b2b_cycles", 32'(cyc), 32'd8);
    idle_check("b2b_end");

    rd = rand_vec();
    nd = rand_vec();
    offer(2'b01, rd);
    drain(2'b01, rd, 0, 4, 1'b0, 2'b00, '0, cyc);
    @(negedge clk);
    check("pre_flush_idx", 32'(dif.out_idx_o), 32'd4);
    dif.flush_i     = 1'b1;
    dif.out_ready_i = 1'b1;
    dif.res_valid_i = 1'b1;
    dif.res_op_i    = 2'b11;
    dif.res_data_i  = rand_vec();
    #1 check("flush_res_ready", 32'(dif.res_ready_o), 32'd0);
    @(posedge clk);
    #1;
    dif.flush_i     = 1'b0;
    dif.out_ready_i = 1'b0;
    dif.res_data_i  = nd;
    @(negedge clk);
    check("flush_valid", 32'(dif.out_valid_o), 32'd0);
    check("flush_busy", 32'(dif.busy_o), 32'd0);
    check("flush_idx", 32'(dif.out_idx_o), 32'd0);
    check("flush_res_ready_after", 32'(dif.res_ready_o), 32'd1);
    @(posedge clk);
    #1 dif.res_valid_i = 1'b0;
    drain(2'b11, nd, 2, 4, 1'b0, 2'b00, '0, cyc);
    idle_check("flush_end");

    for (int i = 0; i < 6; i++) begin
      rop = 2'($urandom);
      rd  = rand_vec();
      offer(rop, rd);
      drain(rop, rd, 2, nwords(rop), 1'b0, 2'b00, '0, cyc);
    end
    idle_check("rand_end");

    rd = rand_vec();
    offer(2'b00, rd);
    drain(2'b00, rd, 0, 5, 1'b0, 2'b00, '0, cyc);
    @(negedge clk);
    check("pre_rst_idx", 32'(dif.out_idx_o), 32'd5);
    #1 rst_l = 1'b0;
    #1;
    check("arst_valid", 32'(dif.out_valid_o), 32'd0);
    check("arst_data", dif.out_data_o, 32'd0);
    check("arst_idx", 32'(dif.out_idx_o), 32'd0);
    check("arst_last", 32'(dif.out_last_o), 32'd0);
    check("arst_busy", 32'(dif.busy_o), 32'd0);
    @(negedge clk);
    rst_l = 1'b1;
    dif.out_ready_i = 1'b1;
    repeat (3) idle_check("arst_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
